// File: rtl/step_scheduler_if.sv
// Control/status bundle between a sequencing controller and step_scheduler.
interface step_scheduler_if;
   logic       clr;
   logic       start;
   logic       hold;
   logic       overflow;
   logic       s0;
   logic       s1;
   logic       s2;
   logic       s3;
   logic       s4;
   logic       s5;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] run_cnt;

   // Controller side: issues requests, observes step selects and status.
   modport master (
      output clr, start, hold, overflow,
      input  s0, s1, s2, s3, s4, s5, busy, done, err, run_cnt
   );

   // Scheduler side.
   modport slave (
      input  clr, start, hold, overflow,
      output s0, s1, s2, s3, s4, s5, busy, done, err, run_cnt
   );
endinterface

// File: rtl/step_scheduler.sv
// Six-step one-hot sequencer with per-step dwell, hold, overflow fault and clear.
// Optional completed-run counter enabled by defining STEP_SCHEDULER_RUN_CNT_EN;
// without it run_cnt is tied to zero.
// A step-5 expiry with start high restarts immediately, so done and s0 coincide.
module step_scheduler #(
   parameter int unsigned DWELL = 4
) (
   input  logic           clk,
   input  logic           reset,
   step_scheduler_if.slave bus
);
   localparam int unsigned DWELL_W = 4;
   localparam int unsigned STEP_W  = 3;
   localparam int unsigned NSTEP   = 6;
   localparam int unsigned CNT_W   = 8;

   // A dwell of zero is treated as one cycle.
   localparam logic [DWELL_W-1:0] DWELL_EFF  =
      (DWELL_W'(DWELL) == '0) ? DWELL_W'(1) : DWELL_W'(DWELL);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_EFF - DWELL_W'(1));
   localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NSTEP - 1);
   localparam logic [NSTEP-1:0]   SEL_ONE    = NSTEP'(1);

   typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

   state_t             state_q, state_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [NSTEP-1:0]   sel_q, sel_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         step_q  <= '0;
         dwell_q <= '0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         sel_q   <= sel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next state with priority clr > overflow > hold > dwell expiry > start.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      dwell_d = dwell_q;
      done_d  = 1'b0;
      if (bus.clr) begin
         state_d = IDLE;
         step_d  = '0;
         dwell_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = RUN;
                  step_d  = '0;
                  dwell_d = '0;
               end
            end
            RUN: begin
               if (bus.overflow) begin
                  state_d = FAULT;
                  step_d  = '0;
                  dwell_d = '0;
               end else if (bus.hold) begin
                  state_d = RUN;
               end else if (dwell_q == DWELL_LAST) begin
                  dwell_d = '0;
                  if (step_q == STEP_LAST) begin
                     done_d  = 1'b1;
                     step_d  = '0;
                     state_d = bus.start ? RUN : IDLE;
                  end else begin
                     step_d = STEP_W'(step_q + STEP_W'(1));
                  end
               end else begin
                  dwell_d = DWELL_W'(dwell_q + DWELL_W'(1));
               end
            end
            FAULT: begin
               state_d = FAULT;
            end
            default: begin
               state_d = IDLE;
               step_d  = '0;
               dwell_d = '0;
            end
         endcase
      end
      sel_d  = (state_d == RUN) ? NSTEP'(SEL_ONE << step_d) : '0;
      busy_d = (state_d == RUN);
      err_d  = (state_d == FAULT);
   end

   assign bus.s0   = sel_q[0];
   assign bus.s1   = sel_q[1];
   assign bus.s2   = sel_q[2];
   assign bus.s3   = sel_q[3];
   assign bus.s4   = sel_q[4];
   assign bus.s5   = sel_q[5];
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

`ifdef STEP_SCHEDULER_RUN_CNT_EN
   logic [CNT_W-1:0] run_cnt_q;

   // Completed-run counter; survives clr, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         run_cnt_q <= '0;
      end else if (done_d) begin
         run_cnt_q <= CNT_W'(run_cnt_q + CNT_W'(1));
      end
   end

   assign bus.run_cnt = run_cnt_q;
`else
   assign bus.run_cnt = CNT_W'(0);
`endif
endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler (DWELL=4): stimulus pushes expected outputs,
// a negedge monitor pops and compares one record per cycle.
module tb_step_scheduler;
   typedef struct packed {
      logic [5:0] s;
      logic       busy;
      logic       done;
      logic       err;
      logic [7:0] cnt;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   pos;
   int   exp_runs;
   exp_t exp_q[$];

   step_scheduler_if bus();

   step_scheduler #(.DWELL(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   // Monitor: compare DUT outputs against the oldest expected record.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [5:0] act_s;
         e = exp_q.pop_front();
         act_s = {bus.s5, bus.s4, bus.s3, bus.s2, bus.s1, bus.s0};
         total++;
         if (act_s !== e.s || bus.busy !== e.busy || bus.done !== e.done ||
             bus.err !== e.err || bus.run_cnt !== e.cnt) begin
            bad++;
            $display("FAIL cycle_outputs t=%0t: actual s=%b busy=%b done=%b err=%b cnt=%0d required s=%b busy=%b done=%b err=%b cnt=%0d",
                     $time, act_s, bus.busy, bus.done, bus.err, bus.run_cnt,
                     e.s, e.busy, e.done, e.err, e.cnt);
         end
      end
   end

   // Drive one edge's inputs and record the outputs required after that edge.
   task automatic tick(input logic rs, input logic cl, input logic st, input logic hd,
                       input logic ov, input logic [5:0] es, input logic ed, input logic ee);
      exp_t e;
      reset        = rs;
      bus.clr      = cl;
      bus.start    = st;
      bus.hold     = hd;
      bus.overflow = ov;
      @(posedge clk);
      if (!rs) exp_runs = 0;
      else if (ed) exp_runs++;
      e.s    = es;
      e.busy = |es;
      e.done = ed;
      e.err  = ee;
`ifdef STEP_SCHEDULER_RUN_CNT_EN
      e.cnt  = 8'(exp_runs);
`else
      e.cnt  = 8'd0;
`endif
      exp_q.push_back(e);
      #1;
   endtask

   // Start edge from IDLE: S0 asserted right after.
   task automatic start_run();
      tick(1, 0, 1, 0, 0, 6'b000001, 0, 0);
      pos = 0;
   endtask

   // Advance n unheld cycles; cycle 24 of a run is the step-5 expiry edge.
   task automatic run_ticks(input int n, input logic st);
      for (int i = 0; i < n; i++) begin
         pos++;
         if (pos == 24) begin
            tick(1, 0, st, 0, 0, st ? 6'b000001 : 6'b000000, 1, 0);
            pos = 0;
         end else begin
            tick(1, 0, st, 0, 0, 6'(1 << (pos / 4)), 0, 0);
         end
      end
   endtask

   task automatic hold_ticks(input int n);
      for (int i = 0; i < n; i++) tick(1, 0, 0, 1, 0, 6'(1 << (pos / 4)), 0, 0);
   endtask

   task automatic idle_tick(input logic ov);
      tick(1, 0, 0, 0, ov, 6'b0, 0, 0);
   endtask

   initial begin
      total = 0; bad = 0; pos = 0; exp_runs = 0;
      reset = 1'b0; bus.clr = 1'b0; bus.start = 1'b0; bus.hold = 1'b0; bus.overflow = 1'b0;

      // Reset two cycles, then a plain run.
      tick(0, 0, 0, 0, 0, 6'b0, 0, 0);
      tick(0, 0, 1, 0, 0, 6'b0, 0, 0);
      idle_tick(0);
      start_run();
      run_ticks(24, 0);
      idle_tick(0);

      // Hold three cycles during S2.
      start_run();
      run_ticks(9, 0);
      hold_ticks(3);
      run_ticks(15, 0);
      idle_tick(0);

      // Overflow during S3, start ignored in FAULT, clr recovers.
      start_run();
      run_ticks(13, 0);
      tick(1, 0, 0, 0, 1, 6'b0, 0, 1);
      tick(1, 0, 1, 0, 0, 6'b0, 0, 1);
      tick(1, 0, 0, 0, 1, 6'b0, 0, 1);
      tick(1, 1, 0, 0, 0, 6'b0, 0, 0);
      idle_tick(1);
      start_run();
      run_ticks(24, 0);

      // clr and overflow together during S1.
      start_run();
      run_ticks(5, 0);
      tick(1, 1, 0, 0, 1, 6'b0, 0, 0);
      idle_tick(0);

      // Three back-to-back runs with start held.
      start_run();
      run_ticks(24, 1);
      run_ticks(24, 1);
      run_ticks(24, 0);
      idle_tick(0);

      // Overflow on the step-5 expiry edge: fault, no done.
      start_run();
      run_ticks(23, 0);
      tick(1, 0, 0, 0, 1, 6'b0, 0, 1);
      tick(1, 1, 0, 0, 0, 6'b0, 0, 0);

      // Reset during S4 aborts, then a normal run.
      start_run();
      run_ticks(17, 0);
      tick(0, 0, 0, 0, 0, 6'b0, 0, 0);
      idle_tick(0);
      start_run();
      run_ticks(24, 0);
      idle_tick(0);

      // 256 completions from reset: counter wraps to zero.
      tick(0, 0, 0, 0, 0, 6'b0, 0, 0);
      start_run();
      for (int r = 0; r < 255; r++) run_ticks(24, 1);
      run_ticks(24, 0);
      idle_tick(0);

      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: actual %0d pending required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/step_scheduler.md
STEP_SCHEDULER -- requirements
Module: step_scheduler

Interface
REQ-001 Parameter DWELL, default 4, 4-bit unsigned clock cycles each step output is held; value 0 SHALL behave as 1.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset.
REQ-004 CLR  input  1  synchronous active-high clear: abort sequence and clear fault.
REQ-005 START  input  1  level-sampled request to run one six-step sequence.
REQ-006 HOLD  input  1  active-high freeze of the dwell counter while running.
REQ-007 OVERFLOW  input  1  active-high datapath overflow; aborts a running sequence.
REQ-008 S0..S5  output  1 each  one-hot step selects to the datapath.
REQ-009 BUSY  output  1  high while a sequence is running.
REQ-010 DONE  output  1  one-cycle pulse on normal completion.
REQ-011 ERR  output  1  high while in FAULT.
REQ-012 RUN_CNT  output  8  completed-sequence count (see Configuration).

Function
REQ-013 States: IDLE, RUN, FAULT; RUN carries a step index 0..5 and a dwell counter.
REQ-014 All outputs registered; S0..S5 SHALL be one-hot in RUN and all-zero in IDLE and FAULT.
REQ-015 IDLE: START=1 sampled at edge k -> RUN, step 0, S0=1 and BUSY=1 from edge k (one-cycle latency from sample).
REQ-016 RUN: each step held exactly DWELL cycles (HOLD low); step n advances to step n+1 on the edge its dwell expires.
REQ-017 HOLD=1 in RUN: dwell counter and step frozen, current Sn stays asserted; no limit on hold duration.
REQ-018 Step 5 dwell expiry -> IDLE; DONE=1 for exactly that one cycle, BUSY=0, S5=0 in the same cycle.
REQ-019 START in RUN or FAULT ignored; START held high in IDLE after DONE restarts on the next edge (back-to-back runs, DONE and S0 coincide).
REQ-020 OVERFLOW=1 in RUN -> FAULT next edge: S0..S5=0, BUSY=0, ERR=1, no DONE; OVERFLOW in IDLE or FAULT ignored.
REQ-021 FAULT persists until CLR=1 or reset, regardless of OVERFLOW deasserting.
REQ-022 CLR=1 in any state -> IDLE next edge, ERR=0, BUSY=0, no DONE.
REQ-023 Priority per edge: RESET > CLR > OVERFLOW > HOLD > dwell expiry > START.
REQ-024 OVERFLOW coinciding with step 5 expiry -> FAULT, no DONE, RUN_CNT unchanged.

Reset
REQ-025 RESET=0 at an edge -> IDLE, S0..S5=0, BUSY=0, DONE=0, ERR=0, RUN_CNT=0, dwell counter=0.
REQ-026 RESET mid-sequence SHALL abort without DONE; first START after release behaves as REQ-015.
REQ-027 No asynchronous behaviour; RESET effective only on rising CLK.

Configuration
REQ-028 Macro STEP_SCHEDULER_RUN_CNT_EN defined: RUN_CNT increments by 1 on each DONE pulse, wraps 255 -> 0, cleared by reset only (not CLR).
REQ-029 Macro undefined: counter logic absent, RUN_CNT SHALL be constant 0; all other behaviour identical.

Verification (DWELL=4, 100 ns clock)
REQ-030 RESET low 2 cycles, then START 1 cycle -> S0..S5 each high 4 cycles in order, 24 cycles BUSY, DONE pulse 1 cycle, RUN_CNT=1 (macro on).
REQ-031 START, HOLD high 3 cycles during S2 -> S2 high 7 cycles, total run 27 cycles, DONE once.
REQ-032 OVERFLOW pulsed during S3 -> next cycle S*=0, ERR=1, BUSY=0; START ignored; CLR 1 cycle -> ERR=0, IDLE; next START runs normally.
REQ-033 CLR and OVERFLOW same cycle during S1 -> IDLE, ERR stays 0, no DONE.
REQ-034 START held high 3 sequences -> DONE coincides with S0 of next run, RUN_CNT=3 (macro on) / 0 (macro off).
REQ-035 256 completed runs with macro on -> RUN_CNT wraps to 0; RESET mid-run in S4 -> all outputs 0 next edge, RUN_CNT=0.
